// File: rtl/cpu_pkg.sv
// Shared types for the register-file write path: register index and queued write entry.
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_NUM_REGS = 32;
  localparam int CPU_REG_W    = $clog2(CPU_NUM_REGS);

  typedef logic [CPU_REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              rd;
    logic [CPU_DATA_W-1:0] data;
  } wb_entry_t;

  // Index 0 is the hardwired zero register, so it never matches a lookup.
  function automatic logic entry_matches(input wb_entry_t e, input reg_idx_t q);
    return (q != '0) && (e.rd == q);
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular buffer of pending register writes: sparse multi-enqueue, single dequeue,
// and a two-port lookup returning the youngest queued value for an index.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int DEPTH       = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic      [NUM_SOURCES-1:0]       enq_valid,
  input  wb_entry_t [NUM_SOURCES-1:0]       enq_entry,
  input  logic                              deq,
  input  reg_idx_t                          query_register_1,
  input  reg_idx_t                          query_register_2,
  output wb_entry_t                         head,
  output logic      [CNT_W-1:0]             count,
  output logic                              query_hit_1,
  output logic                              query_hit_2,
  output logic      [CPU_DATA_W-1:0]        query_data_1,
  output logic      [CPU_DATA_W-1:0]        query_data_2
);

  wb_entry_t                         mem_r [DEPTH];
  logic [PTR_W-1:0]                  head_r;
  logic [CNT_W-1:0]                  count_r;
  logic [NUM_SOURCES-1:0][PTR_W-1:0] off_s;
  logic [CNT_W-1:0]                  enq_count_s;
  logic [PTR_W-1:0]                  slot_s;
  logic                              m1_s;
  logic                              m2_s;

  // Compact the sparse enqueue mask into consecutive offsets behind the tail.
  always_comb begin
    off_s       = '0;
    enq_count_s = '0;
    for (int p = 0; p < NUM_SOURCES; p++) begin
      off_s[p]    = PTR_W'(enq_count_s);
      enq_count_s = enq_count_s + CNT_W'(enq_valid[p]);
    end
  end

  // Buffer state; a slot freed by this cycle's pop may be refilled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      count_r <= '0;
    end else begin
      for (int p = 0; p < NUM_SOURCES; p++) begin
        if (enq_valid[p]) begin
          mem_r[head_r + PTR_W'(count_r) + off_s[p]] <= enq_entry[p];
        end
      end
      head_r  <= deq ? head_r + PTR_W'(1'b1) : head_r;
      count_r <= count_r + enq_count_s - CNT_W'(deq);
    end
  end

  // Lookup scans oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    query_hit_1  = 1'b0;
    query_hit_2  = 1'b0;
    query_data_1 = '0;
    query_data_2 = '0;
    slot_s       = '0;
    m1_s         = 1'b0;
    m2_s         = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_s       = head_r + PTR_W'(j);
      m1_s         = (CNT_W'(j) < count_r) && entry_matches(mem_r[slot_s], query_register_1);
      m2_s         = (CNT_W'(j) < count_r) && entry_matches(mem_r[slot_s], query_register_2);
      query_hit_1  = query_hit_1 | m1_s;
      query_hit_2  = query_hit_2 | m2_s;
      query_data_1 = m1_s ? mem_r[slot_s].data : query_data_1;
      query_data_2 = m2_s ? mem_r[slot_s].data : query_data_2;
    end
  end

  assign head  = mem_r[head_r];
  assign count = count_r;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port front end: round-robin acceptance of completing units into
// an in-order queue, one retirement per cycle, and pending-value lookup for issue.
module regfile_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = CPU_DATA_W,
  parameter int NUM_REGISTERS = CPU_NUM_REGS,
  parameter int NUM_SOURCES   = 3,
  parameter int DEPTH         = 4,
  localparam int REG_W        = $clog2(NUM_REGISTERS),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SOURCES-1:0]                 src_valid,
  input  logic [NUM_SOURCES-1:0][REG_W-1:0]      src_register,
  input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data,
  output logic [NUM_SOURCES-1:0]                 src_ready,
  input  logic                                   hold,
  output logic [REG_W-1:0]                       write_register,
  output logic [DATA_WIDTH-1:0]                  write_data,
  input  logic [REG_W-1:0]                       query_register_1,
  input  logic [REG_W-1:0]                       query_register_2,
  output logic                                   query_hit_1,
  output logic                                   query_hit_2,
  output logic [DATA_WIDTH-1:0]                  query_data_1,
  output logic [DATA_WIDTH-1:0]                  query_data_2,
  output logic [CNT_W-1:0]                       occupancy
);

  localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [SRC_W-1:0]                 rr_r;
  logic [SRC_W-1:0]                 rr_next_s;
  logic [SRC_W-1:0]                 src_s;
  logic [SRC_W:0]                   walk_s;
  logic [CNT_W-1:0]                 free_s;
  logic [CNT_W-1:0]                 slots_s;
  logic [CNT_W-1:0]                 count_s;
  logic                             retire_s;
  logic [NUM_SOURCES-1:0]           enq_valid_s;
  wb_entry_t [NUM_SOURCES-1:0]      enq_entry_s;
  wb_entry_t                        head_s;

  // Nothing retires or is accepted while reset is asserted.
  assign retire_s = (count_s != '0) && !hold && !rst;
  assign free_s   = CNT_W'(DEPTH) - count_s + CNT_W'(retire_s);

  // Round-robin walk: index-0 writes are swallowed, real writes consume free slots in walk order.
  always_comb begin
    src_ready   = '0;
    enq_valid_s = '0;
    enq_entry_s = '0;
    rr_next_s   = rr_r;
    slots_s     = free_s;
    walk_s      = '0;
    src_s       = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      walk_s = {1'b0, rr_r} + (SRC_W + 1)'(k);
      walk_s = (walk_s >= (SRC_W + 1)'(NUM_SOURCES)) ? walk_s - (SRC_W + 1)'(NUM_SOURCES) : walk_s;
      src_s  = walk_s[SRC_W-1:0];
      if (rst || !src_valid[src_s]) begin
        src_ready[src_s] = 1'b0;
      end else if (src_register[src_s] == '0) begin
        src_ready[src_s] = 1'b1;
      end else if (slots_s != '0) begin
        src_ready[src_s]    = 1'b1;
        enq_valid_s[k]      = 1'b1;
        enq_entry_s[k].rd   = src_register[src_s];
        enq_entry_s[k].data = src_data[src_s];
        slots_s             = slots_s - CNT_W'(1'b1);
        rr_next_s           = (src_s == SRC_W'(NUM_SOURCES - 1)) ? '0 : src_s + SRC_W'(1'b1);
      end else begin
        src_ready[src_s] = 1'b0;
      end
    end
  end

  // Arbiter pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r <= '0;
    end else begin
      rr_r <= rr_next_s;
    end
  end

  wb_queue #(
    .NUM_SOURCES (NUM_SOURCES),
    .DEPTH       (DEPTH)
  ) u_queue (
    .clk              (clk),
    .rst              (rst),
    .enq_valid        (enq_valid_s),
    .enq_entry        (enq_entry_s),
    .deq              (retire_s),
    .query_register_1 (query_register_1),
    .query_register_2 (query_register_2),
    .head             (head_s),
    .count            (count_s),
    .query_hit_1      (query_hit_1),
    .query_hit_2      (query_hit_2),
    .query_data_1     (query_data_1),
    .query_data_2     (query_data_2)
  );

  assign write_register = retire_s ? head_s.rd : '0;
  assign write_data     = retire_s ? head_s.data : '0;
  assign occupancy      = count_s;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: queue-level model checked every cycle plus literal spot checks.
module tb_regfile_writeback;

  localparam int NS    = 3;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int RW    = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0][RW-1:0]  src_register;
  logic [NS-1:0][DW-1:0]  src_data;
  logic [NS-1:0]          src_ready;
  logic                   hold;
  logic [RW-1:0]          write_register;
  logic [DW-1:0]          write_data;
  logic [RW-1:0]          query_register_1;
  logic [RW-1:0]          query_register_2;
  logic                   query_hit_1;
  logic                   query_hit_2;
  logic [DW-1:0]          query_data_1;
  logic [DW-1:0]          query_data_2;
  logic [2:0]             occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Model state: pending writes oldest-first and the round-robin start source.
  int          m_rd[$];
  logic [DW-1:0] m_data[$];
  int          m_rr = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .src_valid        (src_valid),
    .src_register     (src_register),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .hold             (hold),
    .write_register   (write_register),
    .write_data       (write_data),
    .query_register_1 (query_register_1),
    .query_register_2 (query_register_2),
    .query_hit_1      (query_hit_1),
    .query_hit_2      (query_hit_2),
    .query_data_1     (query_data_1),
    .query_data_2     (query_data_2),
    .occupancy        (occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Which sources the rules accept this cycle, in walk order.
  function automatic void model_walk(output logic [NS-1:0] rdy, output int acc[NS],
                                     output int nacc, output int nrr, output bit retire);
    int free;
    int s;
    retire = (m_rd.size() > 0) && !hold && !rst;
    free   = DEPTH - m_rd.size() + (retire ? 1 : 0);
    rdy    = '0;
    nacc   = 0;
    nrr    = m_rr;
    for (int k = 0; k < NS; k++) acc[k] = 0;
    if (!rst) begin
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (src_valid[s] && src_register[s] == 0) begin
          rdy[s] = 1'b1;
        end else if (src_valid[s] && free > 0) begin
          rdy[s] = 1'b1;
          free--;
          acc[nacc] = s;
          nacc++;
          nrr = (s + 1) % NS;
        end
      end
    end
  endfunction

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NS-1:0] rdy;
    int acc[NS];
    int nacc;
    int nrr;
    bit retire;
    bit eh1, eh2;
    logic [DW-1:0] ed1, ed2;
    if (check_en) begin
      model_walk(rdy, acc, nacc, nrr, retire);
      eh1 = 1'b0; eh2 = 1'b0; ed1 = '0; ed2 = '0;
      for (int i = 0; i < m_rd.size(); i++) begin
        if (query_register_1 != 0 && m_rd[i] == query_register_1) begin eh1 = 1'b1; ed1 = m_data[i]; end
        if (query_register_2 != 0 && m_rd[i] == query_register_2) begin eh2 = 1'b1; ed2 = m_data[i]; end
      end
      chk("cyc_ready", src_ready, rdy);
      chk("cyc_wr_reg", write_register, retire ? m_rd[0] : 0);
      chk("cyc_wr_data", write_data, retire ? m_data[0] : 0);
      chk("cyc_occ", occupancy, m_rd.size());
      chk("cyc_hit1", query_hit_1, eh1);
      chk("cyc_hit2", query_hit_2, eh2);
      chk("cyc_qdata1", query_data_1, ed1);
      chk("cyc_qdata2", query_data_2, ed2);
    end
  end

  // Advance the model at the active edge.
  always @(posedge clk) begin
    logic [NS-1:0] rdy;
    int acc[NS];
    int nacc;
    int nrr;
    bit retire;
    model_walk(rdy, acc, nacc, nrr, retire);
    if (rst) begin
      m_rd.delete();
      m_data.delete();
      m_rr = 0;
    end else begin
      if (retire) begin
        void'(m_rd.pop_front());
        void'(m_data.pop_front());
      end
      for (int i = 0; i < nacc; i++) begin
        m_rd.push_back(src_register[acc[i]]);
        m_data.push_back(src_data[acc[i]]);
      end
      m_rr = nrr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    while (occupancy != 3'd0 && n < 12) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(name, occupancy, 0);
    tick();
  endtask

  int t2_wr[4]  = '{1, 2, 3, 0};
  int t2_occ[4] = '{3, 2, 1, 0};

  initial begin
    rst = 1'b1; hold = 1'b0; src_valid = '0; src_register = '0; src_data = '0;
    query_register_1 = '0; query_register_2 = '0;
    tick();
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_occ", occupancy, 0);
    chk("reset_wr", write_register, 0);
    chk("reset_ready", src_ready, 0);

    // 1: single write, one-cycle latency
    tick();
    rst = 1'b0; src_valid = 3'b001; src_register[0] = 5'd5; src_data[0] = 32'hAAAA_0001;
    @(negedge clk); chk("t1_ready", src_ready, 3'b001);
    tick(); src_valid = 3'b000;
    @(negedge clk); chk("t1_wr_reg", write_register, 5); chk("t1_wr_data", write_data, 32'hAAAA_0001);
    tick();
    @(negedge clk); chk("t1_wr_idle", write_register, 0);

    // 2: three sources in one cycle from rr=0
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; src_valid = 3'b111;
    src_register[0] = 5'd1; src_register[1] = 5'd2; src_register[2] = 5'd3;
    src_data[0] = 32'h101; src_data[1] = 32'h202; src_data[2] = 32'h303;
    @(negedge clk); chk("t2_ready", src_ready, 3'b111);
    tick(); src_valid = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_wr_reg", write_register, t2_wr[i]);
      chk("t2_occ", occupancy, t2_occ[i]);
      tick();
    end

    // 3: hold fills the queue, then rotation serves waiting sources
    hold = 1'b1; src_valid = 3'b111;
    src_register[0] = 5'd7; src_register[1] = 5'd7; src_register[2] = 5'd7;
    src_data[0] = 32'h70; src_data[1] = 32'h71; src_data[2] = 32'h72;
    @(negedge clk); chk("t3_ready_a", src_ready, 3'b111);
    tick();
    @(negedge clk); chk("t3_ready_b", src_ready, 3'b001); chk("t3_occ_b", occupancy, 3);
    tick();
    @(negedge clk); chk("t3_ready_full", src_ready, 3'b000); chk("t3_occ_full", occupancy, 4);
    tick(); hold = 1'b0;
    @(negedge clk); chk("t3_ready_rr1", src_ready, 3'b010); chk("t3_wr_a", write_data, 32'h70);
    tick();
    @(negedge clk); chk("t3_ready_rr2", src_ready, 3'b100); chk("t3_wr_b", write_data, 32'h71);
    tick(); src_valid = 3'b000;
    drain("t3_drain");

    // 4: youngest match wins, index 0 never hits
    hold = 1'b1; src_valid = 3'b001; src_register[0] = 5'd9; src_data[0] = 32'h11;
    @(negedge clk); chk("t4_ready_a", src_ready, 3'b001);
    tick(); src_data[0] = 32'h22;
    @(negedge clk); chk("t4_ready_b", src_ready, 3'b001);
    tick(); src_valid = 3'b000; query_register_1 = 5'd9; query_register_2 = 5'd0;
    @(negedge clk);
    chk("t4_hit1", query_hit_1, 1); chk("t4_qdata1", query_data_1, 32'h22);
    chk("t4_hit2", query_hit_2, 0); chk("t4_qdata2", query_data_2, 0);

    // 5: zero-index write accepted while full and held
    tick(); src_valid = 3'b101;
    src_register[0] = 5'd4; src_data[0] = 32'h40; src_register[2] = 5'd4; src_data[2] = 32'h42;
    @(negedge clk); chk("t5_fill_ready", src_ready, 3'b101);
    tick(); src_valid = 3'b010; src_register[1] = 5'd0; src_data[1] = 32'hDEAD;
    @(negedge clk); chk("t5_zero_ready", src_ready, 3'b010); chk("t5_occ", occupancy, 4);
    tick();
    @(negedge clk); chk("t5_occ_after", occupancy, 4); chk("t5_no_write", write_register, 0);

    // 6: reset with entries queued
    tick(); src_valid = 3'b000; hold = 1'b0;
    @(negedge clk); chk("t6_wr_head", write_data, 32'h11);
    tick(); rst = 1'b1;
    @(negedge clk); chk("t6_rst_wr", write_register, 0); chk("t6_rst_occ", occupancy, 3);
    tick(); rst = 1'b0; query_register_2 = 5'd4;
    @(negedge clk);
    chk("t6_occ", occupancy, 0); chk("t6_wr", write_register, 0);
    chk("t6_hit1", query_hit_1, 0); chk("t6_hit2", query_hit_2, 0);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
